triangle_tf_sequencer: RTL and testbench
========================================

# triangle_tf_sequencer

Parametrised pipeline head. Holds a scene's model-instance list, walks every instance × every triangle of its model, issues ModelBuffer reads, and emits one `triangle_tf_t` + `triangle_tf_meta_t` per triangle to the transform stage under valid/ready backpressure. Successor of the single-instance feeder: configurable instance depth, ModelBuffer latency and output buffering, with speculative read issue and squash of over-run reads.

## Interface
- `MAX_INSTANCES`, 16, instance RAM depth; index width `IW = $clog2(MAX_INSTANCES)`.
- `MB_LATENCY`, 2, fixed ModelBuffer read latency in cycles, ≥1.
- `FIFO_DEPTH`, 4, output FIFO depth, ≥ `MB_LATENCY+1`.

- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `instance_data` in `modelinstance_t`: scene load beat.
- `instance_meta` in `modelinstance_meta_t`: `last` marks final instance.
- `instance_valid` / `instance_ready` in/out 1: load handshake.
- `frame_start` in 1: one-cycle pulse, begins traversal.
- `busy` out 1: traversal in progress.
- `overflow` out 1: sticky, load exceeded `MAX_INSTANCES`.
- `mb_read` out `modelbuf_read_t`: {model_index, triangle_index}.
- `mb_read_valid` out 1: read strobe (ModelBuffer never stalls).
- `mb_triangle` in `triangle_t`; `mb_triangle_meta` in `triangle_meta_t` (`last` = final triangle of model); `mb_triangle_valid` in 1: return exactly `MB_LATENCY` cycles after strobe.
- `out_data` out `triangle_tf_t`; `out_meta` out `triangle_tf_meta_t`; `out_valid` out 1; `out_ready` in 1.

## Operation
- States: `LOAD`, `LOADED`, `RUN`, `FLUSH`. Reset → `LOAD`.
- `LOAD`: `instance_ready`=1; each accepted beat written at `wr_idx`, `wr_idx++`. Beats beyond `MAX_INSTANCES` dropped, `overflow` set. Beat with `last` → `n_inst = min(count, MAX_INSTANCES)`, go `LOADED`.
- `LOADED`: `instance_ready`=0. `frame_start` → `RUN`, `inst_idx=0`, `tri_idx=0`. New `instance_valid` beat in `LOADED` (not concurrent with `frame_start`) clears list, restarts `LOAD` with that beat.
- `RUN`: issue read `{model_id[inst_idx], tri_idx}` whenever `fifo_count + inflight < FIFO_DEPTH`; `tri_idx++`. Each read carries tag {inst_idx, epoch} through an `MB_LATENCY`-deep shift register.
- Return with tag epoch ≠ current epoch: discarded. Otherwise pushed to FIFO with transform of tagged instance; `triangle_last = mb_triangle_meta.last`; `model_last = triangle_last && (tag inst == n_inst-1)`.
- Accepted return with `last`: epoch toggles (squashes reads issued past model end), issue pointer → `inst_idx=tag+1`, `tri_idx=0`; if tag was final instance stop issuing, go `FLUSH`.
- `FLUSH`: wait until inflight==0 and FIFO empty → `LOADED` (list retained, replayable).
- `frame_start` outside `LOADED` ignored. Every model has ≥1 triangle; zero-triangle models unsupported.
- `busy` = state ∈ {`RUN`,`FLUSH`}.

## Timing
- Reset values: `instance_ready`=1, `busy`=0, `overflow`=0, `mb_read_valid`=0, `out_valid`=0, `mb_read`/`out_data`/`out_meta`=0; counters, epoch, tag valids zero.
- `frame_start` at cycle 0 → first `mb_read_valid` at cycle 1; its return at 1+`MB_LATENCY`; `out_valid` at 2+`MB_LATENCY`.
- Sustained throughput 1 triangle/cycle while `out_ready`=1.
- `out_valid` held, `out_data`/`out_meta` stable until `out_ready`; no combinational ready→valid path.
- Return of `last` and new issue same cycle: issue uses pre-update pointer, its tag carries old epoch → squashed.
- Push and pop same cycle on full FIFO: allowed; credit counting guarantees no accepted return is ever lost.
- `rstn` low mid-frame: everything cleared immediately, instance list invalid, `LOAD` on release; in-flight returns after reset ignored (tag valids cleared).

## Structure
- Add to `types_pkg`: `seq_tag_t` {instance index `IW` bits, epoch bit}; `seq_state_e` enum.
- Instance RAM: inferred register array inside the block.
- One sub-module: `stream_fifo` (parametrised payload width, depth, count output), reusable elsewhere.

## Test plan
- Load 3 instances (models 0,1,2 with 2,1,3 triangles), `MB_LATENCY`=2, `out_ready`=1 → 6 outputs, triangle_last on 2nd,3rd,6th; model_last only on 6th; first `out_valid` cycle 4 after `frame_start`.
- Same scene, `out_ready` toggled 1-of-3 → identical output order, no drops/duplicates, `mb_read_valid` stalls when FIFO+inflight=4.
- Model with 1 triangle, `MB_LATENCY`=4 → 3 speculative reads squashed, exactly one output per instance.
- Load 18 beats into `MAX_INSTANCES`=16 → `overflow`=1, 16 instances traversed, model_last on instance 15.
- `rstn` low during `RUN` → all outputs zero immediately, `instance_ready`=1 after release, late returns ignored.
- Second `frame_start` after `FLUSH` → identical 6-output sequence replayed; `frame_start` during `RUN` ignored.

Source files
------------

// File: rtl/triangle_tf_sequencer_pkg.sv
// rtl/triangle_tf_sequencer_pkg.sv - shared types for the triangle transform sequencer
package triangle_tf_sequencer_pkg;

  localparam int MODEL_W   = 8;
  localparam int TRI_IDX_W = 8;
  localparam int TRI_W     = 32;
  localparam int XF_W      = 16;
  // Tag instance field is wide enough for any supported MAX_INSTANCES (up to 256).
  localparam int SEQ_IW    = 8;

  typedef struct packed {
    logic [MODEL_W-1:0] model_id;
    logic [XF_W-1:0]    transform;
  } modelinstance_t;

  typedef struct packed {
    logic last;
  } modelinstance_meta_t;

  typedef struct packed {
    logic [MODEL_W-1:0]   model_index;
    logic [TRI_IDX_W-1:0] triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic [TRI_W-1:0] vertices;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

  typedef struct packed {
    triangle_t       tri_data;
    logic [XF_W-1:0] transform;
  } triangle_tf_t;

  typedef struct packed {
    logic triangle_last;
    logic model_last;
  } triangle_tf_meta_t;

  typedef struct packed {
    logic [SEQ_IW-1:0] inst;
    logic              epoch;
  } seq_tag_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_LOADED,
    ST_RUN,
    ST_FLUSH
  } seq_state_e;

endpackage

// File: rtl/triangle_tf_sequencer_stream_fifo.sv
// rtl/triangle_tf_sequencer_stream_fifo.sv - generic valid/ready FIFO with occupancy count
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tvalid_i,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [CW-1:0]    count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign pop  = m_tready_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = s_tvalid_i && ((count_q != CW'(DEPTH)) || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata_i;
  end

  assign m_tvalid_o = (count_q != '0);
  assign m_tdata_o  = m_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/triangle_tf_sequencer.sv
// rtl/triangle_tf_sequencer.sv - walks instances x triangles, issues ModelBuffer reads, emits transformed triangles
module triangle_tf_sequencer
  import triangle_tf_sequencer_pkg::*;
#(
  parameter int MAX_INSTANCES = 16,
  parameter int MB_LATENCY    = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  modelinstance_t      instance_data,
  input  modelinstance_meta_t instance_meta,
  input  logic                instance_valid,
  output logic                instance_ready,
  input  logic                frame_start,
  output logic                busy,
  output logic                overflow,
  output modelbuf_read_t      mb_read,
  output logic                mb_read_valid,
  input  triangle_t           mb_triangle,
  input  triangle_meta_t      mb_triangle_meta,
  input  logic                mb_triangle_valid,
  output triangle_tf_t        out_data,
  output triangle_tf_meta_t   out_meta,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int IW   = (MAX_INSTANCES > 1) ? $clog2(MAX_INSTANCES) : 1;
  localparam int CW   = $clog2(MAX_INSTANCES + 1);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = $clog2(FIFO_DEPTH + MB_LATENCY + 1);
  localparam int PAYW = $bits(triangle_tf_t) + $bits(triangle_tf_meta_t);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INSTANCES);

  seq_state_e           state_q, state_d;
  logic [CW-1:0]        wr_idx_q, wr_idx_d, n_inst_q, n_inst_d;
  logic                 overflow_q, overflow_d;
  logic [IW-1:0]        inst_idx_q, inst_idx_d;
  logic [TRI_IDX_W-1:0] tri_idx_q, tri_idx_d;
  logic                 epoch_q, epoch_d;
  logic [MB_LATENCY-1:0] tag_v_q;
  seq_tag_t             tag_q [MB_LATENCY];

  logic [MODEL_W-1:0]   ram_model_q [MAX_INSTANCES];
  logic [XF_W-1:0]      ram_xf_q    [MAX_INSTANCES];

  logic                 ram_we, issue, ret_live, ret_final;
  seq_tag_t             ret_tag;
  logic [IW-1:0]        ret_inst;
  logic [SW-1:0]        inflight, occupancy;
  logic [FCW-1:0]       fifo_count;
  triangle_tf_t         push_data;
  triangle_tf_meta_t    push_meta;
  logic [PAYW-1:0]      pop_payload;

  // Credit: every outstanding read (squashed or not) reserves a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MB_LATENCY; i++) inflight = inflight + SW'(tag_v_q[i]);
    occupancy = inflight + SW'(fifo_count);
  end

  assign issue     = (state_q == ST_RUN) && (occupancy < SW'(FIFO_DEPTH));
  assign ret_tag   = tag_q[MB_LATENCY-1];
  assign ret_inst  = ret_tag.inst[IW-1:0];
  assign ret_live  = mb_triangle_valid && tag_v_q[MB_LATENCY-1] && (ret_tag.epoch == epoch_q);
  assign ret_final = (ret_tag.inst == SEQ_IW'(n_inst_q - CW'(1)));

  always_comb begin
    mb_read = '0;
    if (issue) begin
      mb_read.model_index    = ram_model_q[inst_idx_q];
      mb_read.triangle_index = tri_idx_q;
    end
  end

  always_comb begin
    push_data.tri_data      = mb_triangle;
    push_data.transform     = ram_xf_q[ret_inst];
    push_meta.triangle_last = mb_triangle_meta.last;
    push_meta.model_last    = mb_triangle_meta.last && ret_final;
  end

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    n_inst_d   = n_inst_q;
    overflow_d = overflow_q;
    inst_idx_d = inst_idx_q;
    tri_idx_d  = tri_idx_q;
    epoch_d    = epoch_q;
    ram_we     = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (instance_valid) begin
          if (wr_idx_q < MAX_CNT) begin
            ram_we   = 1'b1;
            wr_idx_d = wr_idx_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (instance_meta.last) begin
            n_inst_d = (wr_idx_q < MAX_CNT) ? wr_idx_q + CW'(1) : MAX_CNT;
            state_d  = ST_LOADED;
          end
        end
      end
      ST_LOADED: begin
        if (frame_start) begin
          state_d    = ST_RUN;
          inst_idx_d = '0;
          tri_idx_d  = '0;
        end else if (instance_valid) begin
          // The pending beat is taken in LOAD on the following cycle.
          state_d  = ST_LOAD;
          wr_idx_d = '0;
          n_inst_d = '0;
        end
      end
      ST_RUN: begin
        if (issue) tri_idx_d = tri_idx_q + TRI_IDX_W'(1);
        // End of model: new epoch squashes reads already issued past the last triangle.
        if (ret_live && mb_triangle_meta.last) begin
          epoch_d    = ~epoch_q;
          tri_idx_d  = '0;
          inst_idx_d = ret_inst + IW'(1);
          if (ret_final) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (inflight == '0 && fifo_count == '0) state_d = ST_LOADED;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_LOAD;
      wr_idx_q   <= '0;
      n_inst_q   <= '0;
      overflow_q <= 1'b0;
      inst_idx_q <= '0;
      tri_idx_q  <= '0;
      epoch_q    <= 1'b0;
      tag_v_q    <= '0;
      for (int i = 0; i < MB_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      n_inst_q   <= n_inst_d;
      overflow_q <= overflow_d;
      inst_idx_q <= inst_idx_d;
      tri_idx_q  <= tri_idx_d;
      epoch_q    <= epoch_d;
      tag_v_q[0] <= issue;
      tag_q[0]   <= '{inst: SEQ_IW'(inst_idx_q), epoch: epoch_q};
      for (int i = 1; i < MB_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_model_q[wr_idx_q[IW-1:0]] <= instance_data.model_id;
      ram_xf_q[wr_idx_q[IW-1:0]]    <= instance_data.transform;
    end
  end

  stream_fifo #(
    .WIDTH(PAYW),
    .DEPTH(FIFO_DEPTH),
    .CW   (FCW)
  ) u_out_fifo (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .s_tdata_i ({push_data, push_meta}),
    .s_tvalid_i(ret_live),
    .m_tdata_o (pop_payload),
    .m_tvalid_o(out_valid),
    .m_tready_i(out_ready),
    .count_o   (fifo_count)
  );

  assign {out_data, out_meta} = pop_payload;
  assign instance_ready       = (state_q == ST_LOAD);
  assign mb_read_valid        = issue;
  assign busy                 = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign overflow             = overflow_q;

endmodule

// File: tb/tb_triangle_tf_sequencer.sv
// tb/tb_triangle_tf_sequencer.sv - randomized self-checking bench for triangle_tf_sequencer
module tb_triangle_tf_sequencer;
  import triangle_tf_sequencer_pkg::*;

  localparam int MAXI = 16;
  localparam int LAT  = 2;
  localparam int FD   = 4;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  modelinstance_t      instance_data;
  modelinstance_meta_t instance_meta;
  logic                instance_valid;
  logic                instance_ready;
  logic                frame_start;
  logic                busy;
  logic                overflow;
  modelbuf_read_t      mb_read;
  logic                mb_read_valid;
  triangle_t           mb_triangle;
  triangle_meta_t      mb_triangle_meta;
  logic                mb_triangle_valid;
  triangle_tf_t        out_data;
  triangle_tf_meta_t   out_meta;
  logic                out_valid;
  logic                out_ready;

  always #5 clk = ~clk;

  triangle_tf_sequencer #(
    .MAX_INSTANCES(MAXI),
    .MB_LATENCY   (LAT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .instance_data    (instance_data),
    .instance_meta    (instance_meta),
    .instance_valid   (instance_valid),
    .instance_ready   (instance_ready),
    .frame_start      (frame_start),
    .busy             (busy),
    .overflow         (overflow),
    .mb_read          (mb_read),
    .mb_read_valid    (mb_read_valid),
    .mb_triangle      (mb_triangle),
    .mb_triangle_meta (mb_triangle_meta),
    .mb_triangle_valid(mb_triangle_valid),
    .out_data         (out_data),
    .out_meta         (out_meta),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int unsigned  ntri [256];
  logic [7:0]   sc_model [$];
  logic [15:0]  sc_xf [$];
  logic [49:0]  exp_q [$];
  logic [49:0]  obs_q [$];
  int           ready_mode = 0;

  function automatic logic [31:0] tri_word(input int m, input int t);
    return {8'(m), 8'(t), 16'(m * 37 + t * 11) ^ 16'hA5A5};
  endfunction

  // ModelBuffer stand-in and output collector, active #1 after every rising edge.
  logic [16:0] rd_pipe [LAT+1];
  logic        prev_hold = 1'b0;
  logic [49:0] prev_beat = '0;
  int          cyc = 0;

  initial begin
    for (int j = 0; j <= LAT; j++) rd_pipe[j] = '0;
    mb_triangle       = '0;
    mb_triangle_meta  = '0;
    mb_triangle_valid = 1'b0;
    out_ready         = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int j = LAT; j > 0; j--) rd_pipe[j] = rd_pipe[j-1];
      rd_pipe[0] = {mb_read_valid, mb_read.model_index, mb_read.triangle_index};
      mb_triangle_valid = rd_pipe[LAT][16];
      if (rd_pipe[LAT][16]) begin
        mb_triangle.vertices  = tri_word(int'(rd_pipe[LAT][15:8]), int'(rd_pipe[LAT][7:0]));
        mb_triangle_meta.last = (rd_pipe[LAT][7:0] == 8'(ntri[rd_pipe[LAT][15:8]] - 1));
      end else begin
        mb_triangle      = '0;
        mb_triangle_meta = '0;
      end
      if (rstn && prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({out_data, out_meta}), 64'(prev_beat));
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) obs_q.push_back({out_data, out_meta});
      prev_hold = rstn && out_valid && !out_ready;
      prev_beat = {out_data, out_meta};
    end
  end

  task automatic load_scene(input int n);
    for (int i = 0; i < n; i++) begin
      instance_data.model_id  = sc_model[i];
      instance_data.transform = sc_xf[i];
      instance_meta.last      = (i == n - 1);
      instance_valid          = 1'b1;
      for (int w = 0; w < 20 && !instance_ready; w++) begin
        @(posedge clk); #1;
      end
      if (!instance_ready) check("load_ready", 64'(instance_ready), 64'd1);
      @(posedge clk); #1;
    end
    instance_valid = 1'b0;
    instance_meta  = '0;
  endtask

  task automatic build_expected(input int n);
    int neff;
    neff = (n < MAXI) ? n : MAXI;
    exp_q.delete();
    for (int i = 0; i < neff; i++) begin
      for (int t = 0; t < int'(ntri[sc_model[i]]); t++) begin
        logic tl;
        tl = (t == int'(ntri[sc_model[i]]) - 1);
        exp_q.push_back({tri_word(int'(sc_model[i]), t), sc_xf[i], tl, tl && (i == neff - 1)});
      end
    end
  endtask

  task automatic run_frame(input int extra_fs, output int first_rd, output int first_ov);
    logic done;
    done     = 1'b0;
    first_rd = -1;
    first_ov = -1;
    obs_q.delete();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      if (first_rd < 0 && mb_read_valid) first_rd = c;
      if (first_ov < 0 && out_valid) first_ov = c;
      frame_start = (c == extra_fs);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    check("frame_done", 64'(done), 64'd1);
  endtask

  task automatic compare_frame(input string name);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic scene_a();
    sc_model.delete();
    sc_xf.delete();
    ntri[0] = 2;
    ntri[1] = 1;
    ntri[2] = 3;
    for (int i = 0; i < 3; i++) begin
      sc_model.push_back(8'(i));
      sc_xf.push_back(16'($urandom));
    end
  endtask

  int fr, fo, n;

  initial begin
    instance_data  = '0;
    instance_meta  = '0;
    instance_valid = 1'b0;
    frame_start    = 1'b0;
    for (int m = 0; m < 256; m++) ntri[m] = 1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_instance_ready", 64'(instance_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_mb_read_valid", 64'(mb_read_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mb_read", 64'(mb_read), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_meta", 64'(out_meta), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic 3-instance scene with full-rate sink.
    scene_a();
    load_scene(3);
    build_expected(3);
    ready_mode = 0;
    run_frame(-1, fr, fo);
    check("first_read_cycle", 64'(fr), 64'd1);
    check("first_out_valid_cycle", 64'(fo), 64'(LAT + 2));
    check("a_overflow", 64'(overflow), 64'd0);
    compare_frame("a");
    check("a_size", 64'(obs_q.size()), 64'd6);
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      logic [49:0] b;
      b = obs_q[i];
      check($sformatf("a_tri_last%0d", i), 64'(b[1]), 64'(i == 1 || i == 2 || i == 5));
      check($sformatf("a_model_last%0d", i), 64'(b[0]), 64'(i == 5));
    end

    // Replay with throttled sink and a frame_start pulse during RUN.
    ready_mode = 1;
    run_frame(3, fr, fo);
    compare_frame("b");
    ready_mode = 0;
    run_frame(-1, fr, fo);
    compare_frame("c");

    // Random scenes with random backpressure.
    for (int it = 0; it < 6; it++) begin
      for (int m = 0; m < 8; m++) ntri[m] = $urandom_range(1, 5);
      n = $urandom_range(1, MAXI);
      sc_model.delete();
      sc_xf.delete();
      for (int i = 0; i < n; i++) begin
        sc_model.push_back(8'($urandom_range(0, 7)));
        sc_xf.push_back(16'($urandom));
      end
      load_scene(n);
      build_expected(n);
      ready_mode = 2;
      run_frame(-1, fr, fo);
      compare_frame($sformatf("rnd%0d", it));
    end

    // Overflow: 18 beats into a 16-entry list.
    sc_model.delete();
    sc_xf.delete();
    for (int i = 0; i < 18; i++) begin
      sc_model.push_back(8'($urandom_range(0, 7)));
      sc_xf.push_back(16'($urandom));
    end
    load_scene(18);
    check("ovf_flag", 64'(overflow), 64'd1);
    build_expected(18);
    ready_mode = 2;
    run_frame(-1, fr, fo);
    compare_frame("ovf");

    // Reset in the middle of a frame.
    ready_mode = 0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_mb_read_valid", 64'(mb_read_valid), 64'd0);
    check("mid_rst_mb_read", 64'(mb_read), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'({out_data, out_meta}), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    obs_q.delete();
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("post_rst_no_output", 64'(obs_q.size()), 64'd0);
    check("post_rst_instance_ready", 64'(instance_ready), 64'd1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("fs_in_load_ignored", 64'(busy), 64'd0);
    scene_a();
    load_scene(3);
    build_expected(3);
    run_frame(-1, fr, fo);
    compare_frame("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
